// File: rtl/controlador_display_pkg.sv
// Shared types and helpers for the two-digit seven-segment display controller.
package pkg_display;

    typedef enum logic [2:0] {
        VACIO,
        NORMAL,
        SIMPLE,
        DOBLE,
        INVALIDO
    } estado_t;

    localparam logic [6:0] SEG_APAGADO = 7'h7F;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int ancho(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/controlador_display_if.sv
// Decoder result bundle delivered to the display controller.
interface controlador_display_if;
    logic       dato_valido;
    logic [6:0] seg_palabra;
    logic [6:0] seg_sindrome;
    logic       error_simple;
    logic       error_doble;
    logic       no_error;

    modport master (
        output dato_valido, seg_palabra, seg_sindrome,
               error_simple, error_doble, no_error
    );

    modport slave (
        input  dato_valido, seg_palabra, seg_sindrome,
               error_simple, error_doble, no_error
    );
endinterface

// File: rtl/controlador_display_generador_tic.sv
// Periodic tick: down-counter reloaded at terminal count, tic high on the wrap cycle.
module generador_tic #(
    parameter int CICLOS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tic
);
    import pkg_display::*;

    localparam int             W     = ancho(CICLOS);
    localparam logic [W-1:0]   CARGA = W'(CICLOS - 1);

    logic [W-1:0] cuenta;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cuenta <= CARGA;
        end else if (cuenta == '0) begin
            cuenta <= CARGA;
        end else begin
            cuenta <= cuenta - W'(1);
        end
    end

    assign tic = (cuenta == '0);

endmodule

// File: rtl/controlador_display.sv
// Captures SECDED decoder results and drives a multiplexed two-digit display,
// blinking on double errors, plus status LEDs and a saturating double-error count.
module controlador_display #(
    parameter int REFRESCO_CICLOS = 50_000,
    parameter int PARPADEO_CICLOS = 12_500_000
) (
    input  logic                        clk,
    input  logic                        rst,
    controlador_display_if.slave        dec,
    input  logic                        swi,
    output logic [6:0]                  segmentos,
    output logic [1:0]                  anodos,
    output logic                        led_simple,
    output logic                        led_doble,
    output logic [3:0]                  cont_dobles
);
    import pkg_display::*;

    estado_t    estado, estado_sig;
    logic [6:0] palabra, sindrome;
    logic [3:0] dobles;
    logic       digito;
    logic       apagado;
    logic       tic_refresco, tic_parpadeo, clr_parpadeo;
    logic [6:0] seg_d0, seg_d1;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= VACIO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        if (dec.dato_valido) begin
            if (dec.error_doble) begin
                estado_sig = DOBLE;
            end else if (dec.error_simple) begin
                estado_sig = SIMPLE;
            end else if (dec.no_error) begin
                estado_sig = NORMAL;
            end else begin
                estado_sig = INVALIDO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            palabra  <= SEG_APAGADO;
            sindrome <= SEG_APAGADO;
            dobles   <= 4'd0;
        end else if (dec.dato_valido) begin
            palabra  <= dec.seg_palabra;
            sindrome <= dec.seg_sindrome;
            if (dec.error_doble && dobles != 4'hF) begin
                dobles <= dobles + 4'd1;
            end
        end
    end

    // Blink timing restarts on every capture so a fresh double error starts "on".
    assign clr_parpadeo = dec.dato_valido || (estado != DOBLE);

    generador_tic #(.CICLOS(REFRESCO_CICLOS)) u_tic_refresco (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .tic (tic_refresco)
    );

    generador_tic #(.CICLOS(PARPADEO_CICLOS)) u_tic_parpadeo (
        .clk (clk),
        .rst (rst),
        .clr (clr_parpadeo),
        .tic (tic_parpadeo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            digito <= 1'b0;
        end else if (tic_refresco) begin
            digito <= ~digito;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_parpadeo) begin
            apagado <= 1'b0;
        end else if (tic_parpadeo) begin
            apagado <= ~apagado;
        end
    end

    always_comb begin
        seg_d0 = SEG_APAGADO;
        seg_d1 = SEG_APAGADO;
        case (estado)
            NORMAL: begin
                seg_d0 = palabra;
                seg_d1 = swi ? sindrome : SEG_APAGADO;
            end
            SIMPLE: begin
                seg_d0 = palabra;
                seg_d1 = sindrome;
            end
            DOBLE: begin
                seg_d0 = apagado ? SEG_APAGADO : sindrome;
                seg_d1 = apagado ? SEG_APAGADO : sindrome;
            end
            INVALIDO: begin
                seg_d0 = swi ? sindrome : palabra;
            end
            default: begin
                seg_d0 = SEG_APAGADO;
                seg_d1 = SEG_APAGADO;
            end
        endcase
    end

    // Digit enable and its segment code share one register stage so they never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            segmentos   <= SEG_APAGADO;
            anodos      <= 2'b10;
            led_simple  <= 1'b0;
            led_doble   <= 1'b0;
            cont_dobles <= 4'd0;
        end else begin
            segmentos   <= digito ? seg_d1 : seg_d0;
            anodos      <= digito ? 2'b01 : 2'b10;
            led_simple  <= (estado == SIMPLE);
            led_doble   <= (estado == DOBLE);
            cont_dobles <= dobles;
        end
    end

endmodule
